// File: rtl/disp_bin_writer_if.sv
// Local bus between disp_bin_writer (master) and the 4-digit display controller (slave).
// Write-only four-phase handshake: the master raises req (cs follows req) with addr/wr_data
// stable, the slave answers rdy=1, the master drops req, the slave drops rdy, and only then
// may addr/wr_data change for the next write.
interface disp_bin_writer_if;
   logic [7:0] addr;
   logic       cs;
   logic       req;
   logic       rnw;
   logic [7:0] wr_data;
   logic       rdy;

   modport master (output addr, output cs, output req, output rnw, output wr_data, input rdy);
   modport slave  (input addr, input cs, input req, input rnw, input wr_data, output rdy);
endinterface

// File: rtl/disp_bin_writer.sv
// Converts a 14-bit binary value to four BCD digits and programs the display controller's
// eight mode/value registers over the req/rdy local bus.
module disp_bin_writer #(
   parameter int unsigned TIMEOUT  = 16,
   parameter bit          BLANK_LZ = 1'b1,
   parameter logic [6:0]  DASH_SEG = 7'h40
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic [13:0]       value,
   input  logic              value_valid,
   output logic              busy,
   output logic              done,
   output logic              err,
   disp_bin_writer_if.master bus,
   output logic [2:0]        dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CONVERT = 3'd1,
      S_REQ     = 3'd2,
      S_WAIT_HI = 3'd3,
      S_WAIT_LO = 3'd4,
      S_FINISH  = 3'd5
   } state_e;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [13:0] bin_q, bin_d;
   logic [15:0] bcd_q, bcd_d;
   logic        ovf_q, ovf_d;
   logic [3:0]  conv_cnt_q, conv_cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  tmo_q, tmo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        req_q, req_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [15:0] bcd_adj;

   function automatic logic [15:0] dabble_adj(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Even index: mode register (mode bit replicated on [3:0]); odd index: value register.
   function automatic logic [7:0] txn_word(input logic [2:0] idx, input logic [15:0] bcd,
                                           input logic ovf);
      logic [3:0] dig;
      logic       upper_zero;
      logic       m;
      logic [6:0] field;
      dig = bcd[{idx[2:1], 2'b00} +: 4];
      case (idx[2:1])
         2'd1:    upper_zero = (bcd[15:4] == 12'd0);
         2'd2:    upper_zero = (bcd[15:8] == 8'd0);
         2'd3:    upper_zero = (bcd[15:12] == 4'd0);
         default: upper_zero = 1'b0;
      endcase
      if (ovf) begin
         m     = 1'b1;
         field = DASH_SEG;
      end else if (BLANK_LZ && upper_zero) begin
         m     = 1'b1;
         field = 7'h00;
      end else begin
         m     = 1'b0;
         field = {3'b000, dig};
      end
      return idx[0] ? {1'b0, field} : {4'h0, {4{m}}};
   endfunction

   assign bcd_adj = dabble_adj(bcd_q);

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      conv_cnt_d = conv_cnt_q;
      idx_d      = idx_q;
      tmo_d      = tmo_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      req_d      = req_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;

      case (state_q)
         S_IDLE, S_FINISH: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (value_valid) begin
               state_d    = S_CONVERT;
               bin_d      = value;
               bcd_d      = 16'd0;
               ovf_d      = (value > 14'd9999);
               conv_cnt_d = 4'd0;
               busy_d     = 1'b1;
            end
         end
         S_CONVERT: begin
            if (conv_cnt_q == 4'd14) begin
               state_d = S_REQ;
               idx_d   = 3'd0;
               addr_d  = 8'd0;
               wdata_d = txn_word(3'd0, bcd_q, ovf_q);
               req_d   = 1'b1;
               tmo_d   = 8'd0;
            end else begin
               bcd_d      = {bcd_adj[14:0], bin_q[13]};
               bin_d      = {bin_q[12:0], 1'b0};
               conv_cnt_d = conv_cnt_q + 4'd1;
            end
         end
         S_REQ: begin
            state_d = S_WAIT_HI;
            tmo_d   = 8'd0;
         end
         S_WAIT_HI: begin
            if (bus.rdy) begin
               req_d   = 1'b0;
               state_d = S_WAIT_LO;
               tmo_d   = 8'd0;
            end else if (tmo_q == TMO_LAST) begin
               req_d   = 1'b0;
               state_d = S_FINISH;
               done_d  = 1'b1;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         S_WAIT_LO: begin
            if (!bus.rdy) begin
               if (idx_q == 3'd7) begin
                  state_d = S_FINISH;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_REQ;
                  idx_d   = idx_q + 3'd1;
                  addr_d  = {5'd0, idx_q + 3'd1};
                  wdata_d = txn_word(idx_q + 3'd1, bcd_q, ovf_q);
                  req_d   = 1'b1;
                  tmo_d   = 8'd0;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_FINISH;
               done_d  = 1'b1;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_q    <= S_IDLE;
         bin_q      <= 14'd0;
         bcd_q      <= 16'd0;
         ovf_q      <= 1'b0;
         conv_cnt_q <= 4'd0;
         idx_q      <= 3'd0;
         tmo_q      <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= 8'd0;
         wdata_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         conv_cnt_q <= conv_cnt_d;
         idx_q      <= idx_d;
         tmo_q      <= tmo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign bus.addr    = addr_q;
   assign bus.cs      = req_q;
   assign bus.req     = req_q;
   assign bus.rnw     = 1'b0;
   assign bus.wr_data = wdata_q;
   assign dbg_state_o = state_q;

endmodule
